// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - pc/instruction fetch queue between i_cache and decode; FETCHQ_BYPASS_EN enables empty-queue bypass
module fetch_queue #(
   parameter int          DEPTH    = 2,
   parameter int          PC_WIDTH = 32,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fetch_req,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   input  logic [31:0]         icache_rdata,
   input  logic                flush,
   input  logic                id_ready,
   output logic                id_valid,
   output logic [PC_WIDTH-1:0] id_pc,
   output logic [31:0]         id_instr,
   output logic                fetch_stall
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [AW:0]         count;
   logic [AW:0]         occupancy;
   logic [AW-1:0]       wr_idx;
   logic [AW-1:0]       rd_idx;
   logic [PC_WIDTH-1:0] pc_mem [DEPTH];
   logic [31:0]         insn_mem [DEPTH];
   logic                infl_v;
   logic [PC_WIDTH-1:0] infl_pc;
   logic                empty;
   logic                push;
   logic                pop;
   logic                accept;

   assign wr_idx    = wr_ptr[AW-1:0];
   assign rd_idx    = rd_ptr[AW-1:0];
   assign count     = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   // Reserve a slot for the word in flight so capture never meets a full queue.
   assign occupancy = count + {{AW{1'b0}}, infl_v};
   assign fetch_stall = (occupancy >= DEPTH_W);
   assign accept    = fetch_req & ~flush & ~fetch_stall;
   assign pop       = ~empty & id_ready & ~flush;

`ifdef FETCHQ_BYPASS_EN
   logic bypass;
   // Word arriving into an empty queue is offered to decode in the same cycle.
   assign bypass   = empty & infl_v & ~flush;
   assign id_valid = ~empty | bypass;
   assign id_pc    = ~empty ? pc_mem[rd_idx]   : (bypass ? infl_pc      : '0);
   assign id_instr = ~empty ? insn_mem[rd_idx] : (bypass ? icache_rdata : NOP_INSN);
   assign push     = infl_v & ~flush & ~(bypass & id_ready);
`else
   assign id_valid = ~empty;
   assign id_pc    = ~empty ? pc_mem[rd_idx]   : '0;
   assign id_instr = ~empty ? insn_mem[rd_idx] : NOP_INSN;
   assign push     = infl_v & ~flush;
`endif

   // In-flight tracking and queue pointers; flush clears everything on the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_v  <= 1'b0;
         infl_pc <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else if (flush) begin
         infl_v  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         infl_v <= accept;
         if (accept) infl_pc <= fetch_pc;
         if (push)   wr_ptr  <= wr_ptr + 1'b1;
         if (pop)    rd_ptr  <= rd_ptr + 1'b1;
      end
   end

   // Queue storage: pair the returning i_cache word with the pc that requested it.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_idx]   <= infl_pc;
         insn_mem[wr_idx] <= icache_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a queue-based reference
module tb_fetch_queue;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic [31:0] icache_rdata = '0;
   logic        flush = 1'b0;
   logic        id_ready = 1'b0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fetch_stall;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } entry_t;

   entry_t      q[$];
   bit          m_infl = 0;
   logic [31:0] m_infl_pc = '0;

   fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .NOP_INSN(NOP)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .icache_rdata(icache_rdata), .flush(flush), .id_ready(id_ready),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .fetch_stall(fetch_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_infl    = 0;
      m_infl_pc = '0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
   task automatic step(input bit req, input logic [31:0] pc, input bit fl, input bit rdy);
      logic [31:0] rdata;
      bit          ev, es, byp;
      logic [31:0] epc, ein;
      @(negedge clk);
      rdata = $urandom;
      fetch_req = req; fetch_pc = pc; flush = fl; id_ready = rdy; icache_rdata = rdata;
      #1;
      byp = 0;
      if (q.size() > 0) begin
         ev = 1; epc = q[0].pc; ein = q[0].insn;
      end else begin
         ev = 0; epc = '0; ein = NOP;
`ifdef FETCHQ_BYPASS_EN
         if (m_infl && !fl) begin
            ev = 1; byp = 1; epc = m_infl_pc; ein = rdata;
         end
`endif
      end
      es = (q.size() + int'(m_infl)) >= DEPTH;
      check("id_valid", {31'd0, id_valid}, {31'd0, ev});
      check("id_pc", id_pc, epc);
      check("id_instr", id_instr, ein);
      check("fetch_stall", {31'd0, fetch_stall}, {31'd0, es});
      @(posedge clk);
      if (fl) begin
         q.delete();
         m_infl = 0;
      end else begin
         if (ev && rdy && !byp) q.delete(0);
         if (m_infl && !(byp && rdy)) q.push_back('{m_infl_pc, rdata});
         m_infl = req && !es;
         if (req && !es) m_infl_pc = pc;
      end
   endtask

   initial begin
      logic [31:0] pc;
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, id_valid}, 32'd0);
      check("rst_pc", id_pc, 32'd0);
      check("rst_instr", id_instr, NOP);
      check("rst_stall", {31'd0, fetch_stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Streaming with decode always ready.
      step(1, 32'h0, 0, 1);
      step(1, 32'h4, 0, 1);
      step(1, 32'h8, 0, 1);
      repeat (3) step(0, 32'h0, 0, 1);

      // Back-pressure: decode stalled, requests keep coming, then one pop.
      for (int i = 0; i < 5; i++) step(1, 32'h20 + 32'(i*4), 0, 0);
      step(1, 32'h40, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 32'h44 + 32'(i*4), 0, 0);

      // Drain, then flush with a queued word plus one in flight at 0x10.
      repeat (4) step(0, 32'h0, 0, 1);
      step(1, 32'h08, 0, 0);
      step(1, 32'h0c, 0, 0);
      step(0, 32'h00, 0, 1);
      step(1, 32'h10, 0, 0);
      step(1, 32'h14, 1, 1);
      step(1, 32'h80, 0, 0);
      repeat (3) step(0, 32'h0, 0, 1);

      // Asynchronous reset mid-stream with two entries queued.
      step(1, 32'h100, 0, 0);
      step(1, 32'h104, 0, 0);
      step(0, 32'h0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'd0, id_valid}, 32'd0);
      check("midrst_instr", id_instr, NOP);
      check("midrst_stall", {31'd0, fetch_stall}, 32'd0);
      model_reset();
      @(negedge clk);
      fetch_req = 1'b0; flush = 1'b0; id_ready = 1'b0;
      rst = 1'b0;

      // Randomized traffic.
      pc = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         bit r, f, d;
         r = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 19) == 0);
         d = ($urandom_range(0, 9) < 6);
         step(r, pc, f, d);
         if (f) pc = {$urandom_range(0, 16'hffff), 2'b00};
         else if (r) pc = pc + 32'd4;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
